// File: rtl/adc_spi_responder.sv
// SPI responder that emulates a 10-bit, 8-channel MCP3008-class ADC.
// It decodes the start/SGL/D2..D0 command and shifts the captured sample out MSB-first, then LSB-first.
`timescale 1ns/1ps
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ad_clk,
  input  logic        cs,
  input  logic        din,
  output logic        dout,
  output logic        dout_oe,
  input  logic [79:0] ch_data,
  output logic [2:0]  ch_sel,
  output logic        sgl,
  output logic        conv_pulse,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_HDR, S_NULL, S_MSB, S_LSB, S_ZERO
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_cs_sync, r_din_sync;
  logic       r_clk_d, r_rise, r_fall, r_din_d, r_armed;
  logic       w_clk_s, w_cs_s, w_din_s;
  logic [9:0] w_ch [8];
  logic [2:0] w_sel;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_hdr;
  logic [9:0] r_shift;
  logic       r_dout, r_oe, r_sgl, r_conv, r_busy;
  logic [2:0] r_ch_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch
      assign w_ch[gi] = ch_data[10*gi +: 10];
    end
  endgenerate

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];
  assign w_din_s = r_din_sync[SYNC_STAGES-1];
  assign w_sel   = {r_hdr[1:0], r_din_d};

  // Strobes are registered, so r_din_d is delayed by one flop to stay aligned with r_rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '0;
      r_cs_sync  <= '0;
      r_din_sync <= '0;
      r_clk_d    <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_din_d    <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ad_clk};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], din};
      r_clk_d    <= w_clk_s;
      r_rise     <= w_clk_s & ~r_clk_d;
      r_fall     <= ~w_clk_s & r_clk_d;
      r_din_d    <= w_din_s;
    end
  end

  // r_armed requires cs to be seen high after reset before a frame is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_armed  <= 1'b0;
      r_cnt    <= '0;
      r_hdr    <= '0;
      r_shift  <= '0;
      r_dout   <= 1'b0;
      r_oe     <= 1'b0;
      r_sgl    <= 1'b0;
      r_ch_sel <= '0;
      r_conv   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_conv <= 1'b0;
      if (w_cs_s) begin
        r_armed <= 1'b1;
        r_state <= S_IDLE;
        r_dout  <= 1'b0;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_armed) begin
              r_state <= S_WAIT;
              r_busy  <= 1'b1;
            end
          end
          S_WAIT: begin
            if (r_rise && r_din_d) begin
              r_state <= S_HDR;
              r_cnt   <= '0;
            end
          end
          S_HDR: begin
            if (r_rise) begin
              r_hdr <= {r_hdr[1:0], r_din_d};
              r_cnt <= r_cnt + 4'd1;
              if (r_cnt == 4'd3) begin
                r_sgl    <= r_hdr[2];
                r_ch_sel <= w_sel;
                r_shift  <= w_ch[w_sel];
                r_conv   <= 1'b1;
                r_state  <= S_NULL;
              end
            end
          end
          S_NULL: begin
            if (r_fall) begin
              r_oe    <= 1'b1;
              r_dout  <= 1'b0;
              r_cnt   <= 4'd9;
              r_state <= S_MSB;
            end
          end
          S_MSB: begin
            if (r_fall) begin
              r_dout <= r_shift[r_cnt];
              if (r_cnt == 4'd0) begin
                r_cnt   <= 4'd1;
                r_state <= S_LSB;
              end else begin
                r_cnt <= r_cnt - 4'd1;
              end
            end
          end
          S_LSB: begin
            if (r_fall) begin
              r_dout <= r_shift[r_cnt];
              if (r_cnt == 4'd9) r_state <= S_ZERO;
              else               r_cnt   <= r_cnt + 4'd1;
            end
          end
          S_ZERO: begin
            if (r_fall) r_dout <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign dout_oe    = r_oe;
  assign ch_sel     = r_ch_sel;
  assign sgl        = r_sgl;
  assign conv_pulse = r_conv;
  assign busy       = r_busy;

endmodule
